// File: rtl/aw_reg_slice.sv
// -----------------------------------------------------------------------------
// aw_reg_slice
//
// Two-entry register slice (skid buffer) for the AXI4 write-address channel.
// It sits between a master port and the AW crossbar inputs. The upstream
// ready comes straight from a flop, so the crossbar's address-decoded ready
// has no combinational path back to the master. The slice still sustains
// one transfer per cycle. The payload passes through untouched.
//
// Optional feature (compile-time macro AW_SLICE_STALL_CNT_EN):
//   adds the ports stall_clr and stall_cnt, plus a saturating 16-bit counter
//   of the cycles in which the crossbar back-pressures a valid address.
//
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   m_AW*             upstream (master-side) AW channel; m_AWREADY is registered
//   c_AW*             downstream (crossbar-side) AW channel, driven from MAIN
//   stall_clr         synchronous clear of stall_cnt (optional)
//   stall_cnt         back-pressure cycle count, saturating (optional)
// -----------------------------------------------------------------------------
module aw_reg_slice #(
    parameter int ID_width   = 6,
    parameter int ADDR_width = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m_AWVALID,
    output logic                  m_AWREADY,
    input  logic [ID_width-1:0]   m_AWID,
    input  logic [ADDR_width-1:0] m_AWADDR,
    input  logic [7:0]            m_AWLEN,
    input  logic [2:0]            m_AWSIZE,
    input  logic [1:0]            m_AWBURST,
    input  logic [3:0]            m_AWCACHE,
    input  logic [1:0]            m_AWLOCK,
    input  logic [2:0]            m_AWPROT,
    input  logic [3:0]            m_AWQOS,
    input  logic [3:0]            m_AWREGION,
    input  logic [0:0]            m_AWUSER,
    output logic                  c_AWVALID,
    input  logic                  c_AWREADY,
    output logic [ID_width-1:0]   c_AWID,
    output logic [ADDR_width-1:0] c_AWADDR,
    output logic [7:0]            c_AWLEN,
    output logic [2:0]            c_AWSIZE,
    output logic [1:0]            c_AWBURST,
    output logic [3:0]            c_AWCACHE,
    output logic [1:0]            c_AWLOCK,
    output logic [2:0]            c_AWPROT,
    output logic [3:0]            c_AWQOS,
    output logic [3:0]            c_AWREGION,
    output logic [0:0]            c_AWUSER
`ifdef AW_SLICE_STALL_CNT_EN
    ,
    input  logic                  stall_clr,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int PW = ID_width + ADDR_width + 31;

    // The state encoding is {main_v, skid_v}. The encoding 01 cannot be
    // reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic            m_ready_reg;
    logic [PW-1:0]   main_reg, skid_reg;
    logic [PW-1:0]   m_payload;
    logic            up_fire, dn_fire;
    logic            load_main_up, load_main_skid, load_skid;

    assign m_payload = {m_AWID, m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST,
                        m_AWCACHE, m_AWLOCK, m_AWPROT, m_AWQOS, m_AWREGION,
                        m_AWUSER};

    assign c_AWVALID = state_reg[1];
    assign m_AWREADY = m_ready_reg;
    assign up_fire   = m_AWVALID & m_ready_reg;
    assign dn_fire   = c_AWVALID & c_AWREADY;

    assign {c_AWID, c_AWADDR, c_AWLEN, c_AWSIZE, c_AWBURST, c_AWCACHE,
            c_AWLOCK, c_AWPROT, c_AWQOS, c_AWREGION, c_AWUSER} = main_reg;

    // Next-state logic and the register load strobes
    always_comb begin
        state_next     = state_reg;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (up_fire) begin
                    state_next   = ONE;
                    load_main_up = 1'b1;
                end
            end
            ONE: begin
                if (up_fire && dn_fire) begin
                    load_main_up = 1'b1;
                end else if (up_fire) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (dn_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // m_AWREADY is low here, so only a drain can happen.
                if (dn_fire) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= EMPTY;
            m_ready_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            // Ready is computed one cycle ahead: it is low exactly while
            // the next state is FULL.
            m_ready_reg <= ~state_next[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (load_main_up) begin
                main_reg <= m_payload;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= m_payload;
            end
        end
    end

`ifdef AW_SLICE_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= 16'd0;
        end else if (stall_clr) begin
            stall_cnt_reg <= 16'd0;
        end else if (c_AWVALID && !c_AWREADY && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
